// File: rtl/aib_axi_credit_bridge.sv
// -----------------------------------------------------------------------------
// aib_axi_credit_bridge
//   Single-clock, register-level model of an AIB AXI bridge. Each of the five
//   AXI channels (AW, W, AR forward; B, R return) passes through its own
//   DEPTH-entry FIFO. A per-channel credit counter gates source ready: credits
//   load when the link comes up, are consumed on every accepted beat and are
//   returned when the beat leaves the FIFO at the sink side.
//
// Ports
//   clk_wr, rst_wr_n            clock, asynchronous active-low reset
//   i_conf_done, m_*_mac_rdy    link qualifiers; link_up follows their AND
//   *_init_*_credit             initial credit per channel (clamped to DEPTH)
//   m_aw*/m_w*/m_ar*            master-side forward channels (sources)
//   s_aw*/s_w*/s_ar*            slave-side forward channels (sinks)
//   s_b*/s_r*                   slave-side return channels (sources)
//   m_b*/m_r*                   master-side return channels (sinks)
//   *_dbg                       {3'b0, link_up, occupancy[3:0], credit[7:0],
//                               beat_count[15:0]} per channel
// -----------------------------------------------------------------------------

// One credit-gated channel: FIFO + credit counter + beat counter.
module aib_credit_chan #(
  parameter int PW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          link_up_d,
  input  logic          link_up_q,
  input  logic [7:0]    init_credit,
  input  logic          src_valid,
  input  logic [PW-1:0] src_payload,
  output logic          src_ready,
  output logic          snk_valid,
  input  logic          snk_ready,
  output logic [PW-1:0] snk_payload,
  output logic [31:0]   dbg
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  DEPTH_C = 8'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    credit_q, credit_d;
  logic [15:0]   beats_q, beats_d;
  logic [7:0]    credit_load;
  logic          push, pop;

  assign src_ready   = link_up_q & (credit_q != 8'd0);
  assign snk_valid   = link_up_q & (cnt_q != 5'd0);
  assign push        = src_valid & src_ready;
  assign pop         = snk_valid & snk_ready;
  assign credit_load = (init_credit > DEPTH_C) ? DEPTH_C : init_credit;

  // Head is forced to zero while empty so an unwritten entry never shows up.
  assign snk_payload = snk_valid ? mem[rd_ptr_q] : '0;

  assign dbg = {3'b000, link_up_q, (cnt_q > 5'd15) ? 4'hF : cnt_q[3:0],
                credit_q, beats_q};

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    beats_d  = beats_q + 16'(push);
    if (!link_up_d) begin
      // Link going (or staying) down: flush and drop all credit.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      credit_d = '0;
    end else if (!link_up_q) begin
      // Rising edge of link_up: FIFO is already empty, load fresh credit.
      credit_d = credit_load;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10: begin cnt_d = cnt_q + 5'd1; credit_d = credit_q - 8'd1; end
        2'b01: begin cnt_d = cnt_q - 5'd1; credit_d = credit_q + 8'd1; end
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= '0;
      beats_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      beats_q  <= beats_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // cnt_q and the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= src_payload;
  end
endmodule

module aib_axi_credit_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 8
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                i_conf_done,
  input  logic                m_ns_mac_rdy,
  input  logic                m_fs_mac_rdy,
  input  logic [7:0]          m_init_aw_credit,
  input  logic [7:0]          m_init_w_credit,
  input  logic [7:0]          m_init_ar_credit,
  input  logic [7:0]          s_init_b_credit,
  input  logic [7:0]          s_init_r_credit,
  // master AW
  input  logic                m_awvalid,
  output logic                m_awready,
  input  logic [ADDR_W-1:0]   m_awaddr,
  input  logic [ID_W-1:0]     m_awid,
  input  logic [7:0]          m_awlen,
  input  logic [2:0]          m_awsize,
  input  logic [1:0]          m_awburst,
  // master W
  input  logic                m_wvalid,
  output logic                m_wready,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_wlast,
  // master AR
  input  logic                m_arvalid,
  output logic                m_arready,
  input  logic [ADDR_W-1:0]   m_araddr,
  input  logic [ID_W-1:0]     m_arid,
  input  logic [7:0]          m_arlen,
  input  logic [2:0]          m_arsize,
  input  logic [1:0]          m_arburst,
  // master B
  output logic                m_bvalid,
  input  logic                m_bready,
  output logic [1:0]          m_bresp,
  output logic [ID_W-1:0]     m_bid,
  // master R
  output logic                m_rvalid,
  input  logic                m_rready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          m_rresp,
  output logic [ID_W-1:0]     m_rid,
  output logic                m_rlast,
  // slave AW
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  // slave W
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  // slave AR
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  // slave B
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid,
  // slave R
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic [ID_W-1:0]     s_rid,
  input  logic                s_rlast,
  // status
  output logic                link_up,
  output logic [31:0]         m_aw_dbg,
  output logic [31:0]         m_w_dbg,
  output logic [31:0]         m_ar_dbg,
  output logic [31:0]         s_b_dbg,
  output logic [31:0]         s_r_dbg
);
  localparam int AX_W = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int W_W  = DATA_W + DATA_W/8 + 1;
  localparam int B_W  = 2 + ID_W;
  localparam int R_W  = DATA_W + 2 + ID_W + 1;

  logic link_up_q, link_up_d;

  assign link_up_d = i_conf_done & m_ns_mac_rdy & m_fs_mac_rdy;
  assign link_up   = link_up_q;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) link_up_q <= 1'b0;
    else           link_up_q <= link_up_d;
  end

  aib_credit_chan #(.PW(AX_W), .DEPTH(DEPTH)) u_aw (
    .clk(clk_wr), .rst_n(rst_wr_n), .link_up_d(link_up_d), .link_up_q(link_up_q),
    .init_credit(m_init_aw_credit),
    .src_valid(m_awvalid),
    .src_payload({m_awaddr, m_awid, m_awlen, m_awsize, m_awburst}),
    .src_ready(m_awready), .snk_valid(s_awvalid), .snk_ready(s_awready),
    .snk_payload({s_awaddr, s_awid, s_awlen, s_awsize, s_awburst}),
    .dbg(m_aw_dbg)
  );

  aib_credit_chan #(.PW(W_W), .DEPTH(DEPTH)) u_w (
    .clk(clk_wr), .rst_n(rst_wr_n), .link_up_d(link_up_d), .link_up_q(link_up_q),
    .init_credit(m_init_w_credit),
    .src_valid(m_wvalid),
    .src_payload({m_wdata, m_wstrb, m_wlast}),
    .src_ready(m_wready), .snk_valid(s_wvalid), .snk_ready(s_wready),
    .snk_payload({s_wdata, s_wstrb, s_wlast}),
    .dbg(m_w_dbg)
  );

  aib_credit_chan #(.PW(AX_W), .DEPTH(DEPTH)) u_ar (
    .clk(clk_wr), .rst_n(rst_wr_n), .link_up_d(link_up_d), .link_up_q(link_up_q),
    .init_credit(m_init_ar_credit),
    .src_valid(m_arvalid),
    .src_payload({m_araddr, m_arid, m_arlen, m_arsize, m_arburst}),
    .src_ready(m_arready), .snk_valid(s_arvalid), .snk_ready(s_arready),
    .snk_payload({s_araddr, s_arid, s_arlen, s_arsize, s_arburst}),
    .dbg(m_ar_dbg)
  );

  aib_credit_chan #(.PW(B_W), .DEPTH(DEPTH)) u_b (
    .clk(clk_wr), .rst_n(rst_wr_n), .link_up_d(link_up_d), .link_up_q(link_up_q),
    .init_credit(s_init_b_credit),
    .src_valid(s_bvalid),
    .src_payload({s_bresp, s_bid}),
    .src_ready(s_bready), .snk_valid(m_bvalid), .snk_ready(m_bready),
    .snk_payload({m_bresp, m_bid}),
    .dbg(s_b_dbg)
  );

  aib_credit_chan #(.PW(R_W), .DEPTH(DEPTH)) u_r (
    .clk(clk_wr), .rst_n(rst_wr_n), .link_up_d(link_up_d), .link_up_q(link_up_q),
    .init_credit(s_init_r_credit),
    .src_valid(s_rvalid),
    .src_payload({s_rdata, s_rresp, s_rid, s_rlast}),
    .src_ready(s_rready), .snk_valid(m_rvalid), .snk_ready(m_rready),
    .snk_payload({m_rdata, m_rresp, m_rid, m_rlast}),
    .dbg(s_r_dbg)
  );
endmodule

// File: tb/tb_aib_axi_credit_bridge.sv
// -----------------------------------------------------------------------------
// tb_aib_axi_credit_bridge
//   Directed scenarios for reset, single write/read, credit exhaustion, link
//   gating, credit clamping and reset mid-burst, followed by a randomized run
//   checked against a queue-based model of the five channels.
// -----------------------------------------------------------------------------
module tb_aib_axi_credit_bridge;
  localparam int DEPTH = 8;
  localparam int PWID [5] = '{49, 37, 49, 6, 39};

  logic clk_wr = 1'b0;
  logic rst_wr_n;
  logic i_conf_done, m_ns_mac_rdy, m_fs_mac_rdy;
  logic [7:0] m_init_aw_credit, m_init_w_credit, m_init_ar_credit;
  logic [7:0] s_init_b_credit, s_init_r_credit;
  logic m_awvalid, m_awready; logic [31:0] m_awaddr; logic [3:0] m_awid;
  logic [7:0] m_awlen; logic [2:0] m_awsize; logic [1:0] m_awburst;
  logic m_wvalid, m_wready; logic [31:0] m_wdata; logic [3:0] m_wstrb; logic m_wlast;
  logic m_arvalid, m_arready; logic [31:0] m_araddr; logic [3:0] m_arid;
  logic [7:0] m_arlen; logic [2:0] m_arsize; logic [1:0] m_arburst;
  logic m_bvalid, m_bready; logic [1:0] m_bresp; logic [3:0] m_bid;
  logic m_rvalid, m_rready; logic [31:0] m_rdata; logic [1:0] m_rresp;
  logic [3:0] m_rid; logic m_rlast;
  logic s_awvalid, s_awready; logic [31:0] s_awaddr; logic [3:0] s_awid;
  logic [7:0] s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
  logic s_wvalid, s_wready; logic [31:0] s_wdata; logic [3:0] s_wstrb; logic s_wlast;
  logic s_arvalid, s_arready; logic [31:0] s_araddr; logic [3:0] s_arid;
  logic [7:0] s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
  logic s_bvalid, s_bready; logic [1:0] s_bresp; logic [3:0] s_bid;
  logic s_rvalid, s_rready; logic [31:0] s_rdata; logic [1:0] s_rresp;
  logic [3:0] s_rid; logic s_rlast;
  logic link_up;
  logic [31:0] m_aw_dbg, m_w_dbg, m_ar_dbg, s_b_dbg, s_r_dbg;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [63:0] mq [5][$];
  int loaded [5];
  int beats [5];

  always #5 clk_wr = ~clk_wr;

  aib_axi_credit_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH(DEPTH)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .i_conf_done(i_conf_done),
    .m_ns_mac_rdy(m_ns_mac_rdy), .m_fs_mac_rdy(m_fs_mac_rdy),
    .m_init_aw_credit(m_init_aw_credit), .m_init_w_credit(m_init_w_credit),
    .m_init_ar_credit(m_init_ar_credit), .s_init_b_credit(s_init_b_credit),
    .s_init_r_credit(s_init_r_credit),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .link_up(link_up), .m_aw_dbg(m_aw_dbg), .m_w_dbg(m_w_dbg), .m_ar_dbg(m_ar_dbg),
    .s_b_dbg(s_b_dbg), .s_r_dbg(s_r_dbg)
  );

  // ---------------- channel access helpers (0=AW 1=W 2=AR 3=B 4=R) ----------
  task automatic set_src(input int c, input logic v, input logic [63:0] p);
    case (c)
      0: begin m_awvalid = v; {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst} = p[48:0]; end
      1: begin m_wvalid = v; {m_wdata, m_wstrb, m_wlast} = p[36:0]; end
      2: begin m_arvalid = v; {m_araddr, m_arid, m_arlen, m_arsize, m_arburst} = p[48:0]; end
      3: begin s_bvalid = v; {s_bresp, s_bid} = p[5:0]; end
      4: begin s_rvalid = v; {s_rdata, s_rresp, s_rid, s_rlast} = p[38:0]; end
      default: ;
    endcase
  endtask

  task automatic set_snk_ready(input int c, input logic r);
    case (c)
      0: s_awready = r;
      1: s_wready  = r;
      2: s_arready = r;
      3: m_bready  = r;
      4: m_rready  = r;
      default: ;
    endcase
  endtask

  function automatic logic get_src_ready(input int c);
    case (c)
      0: return m_awready;
      1: return m_wready;
      2: return m_arready;
      3: return s_bready;
      4: return s_rready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic get_snk_valid(input int c);
    case (c)
      0: return s_awvalid;
      1: return s_wvalid;
      2: return s_arvalid;
      3: return m_bvalid;
      4: return m_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] get_snk_payload(input int c);
    case (c)
      0: return {15'd0, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst};
      1: return {27'd0, s_wdata, s_wstrb, s_wlast};
      2: return {15'd0, s_araddr, s_arid, s_arlen, s_arsize, s_arburst};
      3: return {58'd0, m_bresp, m_bid};
      4: return {25'd0, m_rdata, m_rresp, m_rid, m_rlast};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] get_dbg(input int c);
    case (c)
      0: return m_aw_dbg;
      1: return m_w_dbg;
      2: return m_ar_dbg;
      3: return s_b_dbg;
      4: return s_r_dbg;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [9:0] handshake_vec();
    return {m_awready, m_wready, m_arready, s_bready, s_rready,
            s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid};
  endfunction

  task automatic cyc();
    @(posedge clk_wr);
    @(negedge clk_wr);
  endtask

  task automatic set_inits(input int aw, input int w, input int ar, input int b, input int r);
    m_init_aw_credit = 8'(aw); m_init_w_credit = 8'(w); m_init_ar_credit = 8'(ar);
    s_init_b_credit  = 8'(b);  s_init_r_credit = 8'(r);
  endtask

  // Drop the link for one cycle, apply new initial credits, bring it back up.
  task automatic relink(input int aw, input int w, input int ar, input int b, input int r);
    i_conf_done = 1'b0;
    cyc();
    set_inits(aw, w, ar, b, r);
    i_conf_done = 1'b1;
    cyc();
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < 5; c++) begin
      set_src(c, 1'b0, 64'd0);
      set_snk_ready(c, 1'b0);
    end
  endtask

  // ---------------- directed scenarios ---------------------------------------
  task automatic test_reset();
    idle_inputs();
    set_inits(8, 8, 8, 8, 8);
    i_conf_done = 1'b1; m_ns_mac_rdy = 1'b1; m_fs_mac_rdy = 1'b1;
    rst_wr_n = 1'b0;
    cyc(); cyc();
    tests++;
    if (link_up !== 1'b0) begin fails++; $display("FAIL reset_link_up: got %b want 0", link_up); end
    tests++;
    if (handshake_vec() !== 10'd0) begin
      fails++; $display("FAIL reset_ready_valid: got %b want 0", handshake_vec());
    end
    tests++;
    if ({s_awaddr, s_wdata, s_araddr, m_bresp, m_bid, m_rdata, m_rid, m_rlast} !== '0) begin
      fails++; $display("FAIL reset_payload: sink payloads not zero");
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (get_dbg(c) !== 32'd0) begin
        fails++; $display("FAIL reset_dbg[%0d]: got %h want 0", c, get_dbg(c));
      end
    end
    rst_wr_n = 1'b1;
    cyc();
    tests++;
    if (link_up !== 1'b1) begin fails++; $display("FAIL release_link_up: got %b want 1", link_up); end
    tests++;
    if (m_aw_dbg !== 32'h1008_0000) begin
      fails++; $display("FAIL release_aw_dbg: got %h want 10080000", m_aw_dbg);
    end
  endtask

  task automatic test_single_write();
    s_awready = 1'b1; s_wready = 1'b1;
    m_awvalid = 1'b1; m_awaddr = 32'h1000; m_awid = 4'h3;
    m_awlen = 8'd0; m_awsize = 3'd3; m_awburst = 2'd1;
    tests++;
    if (m_awready !== 1'b1) begin fails++; $display("FAIL wr_awready: got %b want 1", m_awready); end
    cyc();
    m_awvalid = 1'b0;
    tests++;
    if ({s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst} !== {1'b1, 32'h1000, 4'h3, 8'd0, 3'd3, 2'd1}) begin
      fails++; $display("FAIL wr_s_aw: got v=%b addr=%h id=%h len=%0d size=%0d burst=%0d want 1/1000/3/0/3/1",
                        s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst);
    end
    tests++;
    if (m_aw_dbg[15:0] !== 16'd1) begin fails++; $display("FAIL wr_aw_count: got %0d want 1", m_aw_dbg[15:0]); end
    m_wvalid = 1'b1; m_wdata = 32'hABCD_1234; m_wstrb = 4'hF; m_wlast = 1'b1;
    cyc();
    m_wvalid = 1'b0;
    tests++;
    if ({s_wvalid, s_wdata, s_wstrb, s_wlast} !== {1'b1, 32'hABCD_1234, 4'hF, 1'b1}) begin
      fails++; $display("FAIL wr_s_w: got v=%b data=%h strb=%h last=%b want 1/abcd1234/f/1",
                        s_wvalid, s_wdata, s_wstrb, s_wlast);
    end
    s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h3; m_bready = 1'b0;
    cyc();
    s_bvalid = 1'b0;
    tests++;
    if ({m_bvalid, m_bresp, m_bid} !== {1'b1, 2'b00, 4'h3}) begin
      fails++; $display("FAIL wr_m_b: got v=%b resp=%b id=%h want 1/00/3", m_bvalid, m_bresp, m_bid);
    end
    m_bready = 1'b1;
    cyc();
    tests++;
    if (m_bvalid !== 1'b0 || s_b_dbg[23:16] !== 8'd8) begin
      fails++; $display("FAIL wr_b_pop: got v=%b credit=%0d want 0/8", m_bvalid, s_b_dbg[23:16]);
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    s_arready = 1'b1;
    m_arvalid = 1'b1; m_araddr = 32'h2000; m_arid = 4'h5;
    m_arlen = 8'd0; m_arsize = 3'd2; m_arburst = 2'd1;
    cyc();
    m_arvalid = 1'b0;
    tests++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h2000 || s_arid !== 4'h5) begin
      fails++; $display("FAIL rd_s_ar: got v=%b addr=%h id=%h want 1/2000/5", s_arvalid, s_araddr, s_arid);
    end
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; s_rid = 4'h5; s_rlast = 1'b1;
    m_rready = 1'b0;
    cyc();
    s_rvalid = 1'b0;
    tests++;
    if ({m_rvalid, m_rdata, m_rresp, m_rid, m_rlast} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 4'h5, 1'b1}) begin
      fails++; $display("FAIL rd_m_r: got v=%b data=%h resp=%b id=%h last=%b want 1/deadbeef/00/5/1",
                        m_rvalid, m_rdata, m_rresp, m_rid, m_rlast);
    end
    tests++;
    if (s_r_dbg[23:16] !== 8'd7) begin fails++; $display("FAIL rd_r_credit_used: got %0d want 7", s_r_dbg[23:16]); end
    m_rready = 1'b1;
    cyc();
    tests++;
    if (s_r_dbg[23:16] !== 8'd8 || m_rvalid !== 1'b0) begin
      fails++; $display("FAIL rd_r_credit_back: got credit=%0d v=%b want 8/0", s_r_dbg[23:16], m_rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_credit_exhaustion();
    relink(2, 8, 8, 8, 8);
    tests++;
    if (m_aw_dbg[27:16] !== 12'h002) begin fails++; $display("FAIL ex_load: got %h want 002", m_aw_dbg[27:16]); end
    s_awready = 1'b0;
    m_awvalid = 1'b1; m_awaddr = 32'hA0; m_awlen = 8'd0; m_awid = 4'h1;
    cyc();
    m_awaddr = 32'hA1;
    cyc();
    m_awaddr = 32'hA2;
    tests++;
    if (m_awready !== 1'b0) begin fails++; $display("FAIL ex_awready: got %b want 0", m_awready); end
    tests++;
    if (m_aw_dbg[23:16] !== 8'd0 || m_aw_dbg[27:24] !== 4'd2) begin
      fails++; $display("FAIL ex_dbg: got credit=%0d occ=%0d want 0/2", m_aw_dbg[23:16], m_aw_dbg[27:24]);
    end
    cyc();
    tests++;
    if (s_awaddr !== 32'hA0 || m_awready !== 1'b0) begin
      fails++; $display("FAIL ex_hold: got addr=%h ready=%b want a0/0", s_awaddr, m_awready);
    end
    s_awready = 1'b1;
    cyc();
    tests++;
    if (m_awready !== 1'b1 || s_awaddr !== 32'hA1) begin
      fails++; $display("FAIL ex_after_pop: got ready=%b addr=%h want 1/a1", m_awready, s_awaddr);
    end
    cyc();
    m_awvalid = 1'b0;
    tests++;
    if (s_awaddr !== 32'hA2 || m_aw_dbg[27:16] !== 12'h101) begin
      fails++; $display("FAIL ex_third: got addr=%h occ/credit=%h want a2/101", s_awaddr, m_aw_dbg[27:16]);
    end
    cyc();
    tests++;
    if (s_awvalid !== 1'b0 || m_aw_dbg[27:16] !== 12'h002) begin
      fails++; $display("FAIL ex_drain: got v=%b occ/credit=%h want 0/002", s_awvalid, m_aw_dbg[27:16]);
    end
    idle_inputs();
  endtask

  task automatic test_link_gating();
    relink(8, 8, 8, 8, 8);
    s_awready = 1'b0;
    m_awvalid = 1'b1; m_awaddr = 32'h55;
    cyc();
    m_awvalid = 1'b0;
    tests++;
    if (s_awvalid !== 1'b1) begin fails++; $display("FAIL gate_pre: got s_awvalid=%b want 1", s_awvalid); end
    m_fs_mac_rdy = 1'b0;
    cyc();
    tests++;
    if (link_up !== 1'b0) begin fails++; $display("FAIL gate_link_down: got %b want 0", link_up); end
    tests++;
    if (handshake_vec() !== 10'd0) begin
      fails++; $display("FAIL gate_handshakes: got %b want 0", handshake_vec());
    end
    tests++;
    if (m_aw_dbg[28:16] !== 13'd0) begin fails++; $display("FAIL gate_flush: got %h want 0", m_aw_dbg[28:16]); end
    i_conf_done = 1'b0; m_fs_mac_rdy = 1'b1;
    cyc();
    tests++;
    if (link_up !== 1'b0) begin fails++; $display("FAIL gate_conf: got %b want 0", link_up); end
    idle_inputs();
  endtask

  task automatic test_credit_clamp();
    // link is down here (i_conf_done low)
    set_inits(20, 0, 5, 8, 16);
    i_conf_done = 1'b1;
    #1;
    tests++;
    if (link_up !== 1'b0) begin fails++; $display("FAIL clamp_not_yet: got %b want 0", link_up); end
    cyc();
    tests++;
    if (link_up !== 1'b1) begin fails++; $display("FAIL clamp_link_up: got %b want 1", link_up); end
    tests++;
    if ({m_aw_dbg[23:16], m_w_dbg[23:16], m_ar_dbg[23:16], s_b_dbg[23:16], s_r_dbg[23:16]} !==
        {8'd8, 8'd0, 8'd5, 8'd8, 8'd8}) begin
      fails++; $display("FAIL clamp_credits: got %0d %0d %0d %0d %0d want 8 0 5 8 8",
                        m_aw_dbg[23:16], m_w_dbg[23:16], m_ar_dbg[23:16], s_b_dbg[23:16], s_r_dbg[23:16]);
    end
    m_wvalid = 1'b1; s_wready = 1'b1;
    cyc(); cyc(); cyc();
    tests++;
    if (m_wready !== 1'b0 || s_wvalid !== 1'b0) begin
      fails++; $display("FAIL clamp_zero_blocks: got ready=%b s_wvalid=%b want 0/0", m_wready, s_wvalid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    relink(8, 8, 8, 8, 8);
    s_awready = 1'b0;
    m_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_awaddr = 32'hC0 + 32'(i);
      cyc();
    end
    m_awvalid = 1'b0;
    tests++;
    if (m_aw_dbg[27:24] !== 4'd3) begin fails++; $display("FAIL rst_mid_queued: got %0d want 3", m_aw_dbg[27:24]); end
    rst_wr_n = 1'b0;
    #1;
    tests++;
    if (link_up !== 1'b0 || handshake_vec() !== 10'd0 || m_aw_dbg !== 32'd0 || s_awaddr !== 32'd0) begin
      fails++; $display("FAIL rst_mid_async: got link=%b hs=%b dbg=%h addr=%h want all 0",
                        link_up, handshake_vec(), m_aw_dbg, s_awaddr);
    end
    cyc();
    rst_wr_n = 1'b1;
    tests++;
    if (m_aw_dbg !== 32'd0) begin fails++; $display("FAIL rst_mid_release: got %h want 0", m_aw_dbg); end
    cyc();
    tests++;
    if (m_aw_dbg !== 32'h1008_0000 || s_awvalid !== 1'b0) begin
      fails++; $display("FAIL rst_mid_relink: got dbg=%h v=%b want 10080000/0", m_aw_dbg, s_awvalid);
    end
  endtask

  // ---------------- randomized run against the queue model -------------------
  task automatic test_random();
    int   init [5];
    int   down;
    logic link, qual;
    logic sv [5];
    logic kr [5];
    logic hs_s [5];
    logic hs_k [5];
    logic [63:0] sp [5];
    int   occ, cr;
    logic er, ev;
    logic [31:0] edbg;

    idle_inputs();
    rst_wr_n = 1'b0;
    cyc();
    for (int c = 0; c < 5; c++) init[c] = $urandom_range(1, 12);
    set_inits(init[0], init[1], init[2], init[3], init[4]);
    i_conf_done = 1'b1; m_ns_mac_rdy = 1'b1; m_fs_mac_rdy = 1'b1;
    rst_wr_n = 1'b1;
    cyc();
    for (int c = 0; c < 5; c++) begin
      mq[c].delete();
      loaded[c] = (init[c] > DEPTH) ? DEPTH : init[c];
      beats[c] = 0;
    end
    link = 1'b1;
    down = 0;

    for (int k = 0; k < 800; k++) begin
      if (down > 0) down--;
      else if ($urandom_range(0, 99) < 2) down = $urandom_range(1, 3);
      qual = (down == 0);
      i_conf_done = qual;
      for (int c = 0; c < 5; c++) begin
        sv[c] = ($urandom_range(0, 99) < 60);
        kr[c] = ($urandom_range(0, 99) < 55);
        sp[c] = {$urandom(), $urandom()} & ((64'd1 << PWID[c]) - 64'd1);
        set_src(c, sv[c], sp[c]);
        set_snk_ready(c, kr[c]);
      end
      #1;
      tests++;
      if (link_up !== link) begin fails++; $display("FAIL rnd_link[%0d]: got %b want %b", k, link_up, link); end
      for (int c = 0; c < 5; c++) begin
        occ = mq[c].size();
        cr  = link ? loaded[c] - occ : 0;
        er  = link && (cr > 0);
        ev  = link && (occ > 0);
        tests++;
        if (get_src_ready(c) !== er) begin
          fails++; $display("FAIL rnd_ready[%0d] ch%0d: got %b want %b", k, c, get_src_ready(c), er);
        end
        tests++;
        if (get_snk_valid(c) !== ev) begin
          fails++; $display("FAIL rnd_valid[%0d] ch%0d: got %b want %b", k, c, get_snk_valid(c), ev);
        end
        if (ev) begin
          tests++;
          if (get_snk_payload(c) !== mq[c][0]) begin
            fails++; $display("FAIL rnd_payload[%0d] ch%0d: got %h want %h", k, c, get_snk_payload(c), mq[c][0]);
          end
        end
        edbg = {3'b000, link, 4'(occ), 8'(cr), 16'(beats[c])};
        tests++;
        if (get_dbg(c) !== edbg) begin
          fails++; $display("FAIL rnd_dbg[%0d] ch%0d: got %h want %h", k, c, get_dbg(c), edbg);
        end
        hs_s[c] = sv[c] && er;
        hs_k[c] = kr[c] && ev;
      end
      for (int c = 0; c < 5; c++) begin
        if (hs_s[c]) beats[c] = (beats[c] + 1) % 65536;
        if (!qual) mq[c].delete();
        else if (!link) loaded[c] = (init[c] > DEPTH) ? DEPTH : init[c];
        else begin
          if (hs_k[c]) void'(mq[c].pop_front());
          if (hs_s[c]) mq[c].push_back(sp[c]);
        end
      end
      link = qual;
      cyc();
    end
    idle_inputs();
    i_conf_done = 1'b1;
    cyc();
  endtask

  initial begin
    rst_wr_n = 1'b0;
    i_conf_done = 1'b0; m_ns_mac_rdy = 1'b0; m_fs_mac_rdy = 1'b0;
    idle_inputs();
    set_inits(8, 8, 8, 8, 8);
    @(negedge clk_wr);
    test_reset();
    test_single_write();
    test_single_read();
    test_credit_exhaustion();
    test_link_gating();
    test_credit_clamp();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
